// File: rtl/i2c_mem_slave_burst_pkg.sv
// Shared definitions for the burst I2C memory slave: FSM states, bus-level
// constants and the address helper used at the end of the address byte.
package i2c_mem_slave_burst_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_t;

  // Open-drain levels as seen on SDA.
  localparam logic SDA_ACK     = 1'b0;
  localparam logic SDA_NACK    = 1'b1;
  localparam logic SDA_RELEASE = 1'b1;

  // Bus addresses known to this slave.
  localparam logic [6:0] ADDR_GENERAL_CALL = 7'h00;
  localparam logic [6:0] ADDR_MEM_BURST    = 7'h1F;

  // General call is never claimed, even if the slave address is set to it.
  function automatic logic addr_hit(input logic [6:0] addr, input logic [6:0] own);
    return (addr == own) && (addr != ADDR_GENERAL_CALL);
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Oversamples SCL/SDA on the system clock: synchroniser chain, one edge
// register, and decode of SCL edges plus START/STOP conditions.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_q;
  logic                   sda_q;

  // Synchronise both lines and keep the previous synced value for edge decode;
  // reset to the idle-bus level so leaving reset never looks like an edge.
  // NOTE: sequential state uses <= so every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_raw};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_raw};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_q;
  assign scl_fall  = ~scl_s &  scl_q;
  // SDA may only move while SCL is low; a move with SCL stable high is a bus condition.
  assign start_det =  scl_s &  scl_q &  sda_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_q & ~sda_q &  sda_s;

endmodule

// File: rtl/i2c_mem_slave_burst.sv
// I2C memory slave with register pointer and auto-incrementing burst
// read/write. SDA is changed only on SCL falls; bits are sampled on SCL rises.
module i2c_mem_slave_burst
  import i2c_mem_slave_burst_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = ADDR_MEM_BURST,
  parameter int         MEM_DEPTH   = 64,
  parameter int         PTR_W       = $clog2(MEM_DEPTH),  // derived; leave at default
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SCL_I,
  input  logic             SDA_I,
  output logic             SDA_O,
  output logic             busy,
  output logic             wr_pulse,
  output logic             rd_pulse,
  output logic [PTR_W-1:0] ptr
);

  logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
  state_t     state, state_nxt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] rx_byte;
  logic       last_bit;
  logic [7:0] mem [MEM_DEPTH];

  // Control strobes from the FSM to the datapath.
  logic cnt_clr, cnt_inc;
  logic shift_in, shift_out, load_rd;
  logic wr_en, ptr_set, ptr_inc;
  logic sda_set, sda_val;
  logic busy_set, busy_clr;

  i2c_bus_monitor #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_mon (
    .clk       (clk),
    .rst       (rst),
    .scl_raw   (SCL_I),
    .sda_raw   (SDA_I),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Byte completed by the current SCL rise, and whether that rise is the 8th.
  assign rx_byte  = {shift[6:0], sda_s};
  assign last_bit = (bit_cnt == 3'd7);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath strobes; bus conditions outrank bit handling.
  // NOTE: every signal gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    shift_in  = 1'b0;
    shift_out = 1'b0;
    load_rd   = 1'b0;
    wr_en     = 1'b0;
    ptr_set   = 1'b0;
    ptr_inc   = 1'b0;
    sda_set   = 1'b0;
    sda_val   = SDA_RELEASE;
    busy_set  = 1'b0;
    busy_clr  = 1'b0;

    if (stop_det) begin
      state_nxt = ST_IDLE;
      cnt_clr   = 1'b1;
      sda_set   = 1'b1;
      busy_clr  = 1'b1;
    end else if (start_det) begin
      // Repeated START keeps ptr so a pointer write can be followed by a read.
      state_nxt = ST_ADDR;
      cnt_clr   = 1'b1;
      sda_set   = 1'b1;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_in = 1'b1;
            cnt_inc  = 1'b1;
            if (last_bit) begin
              if (addr_hit(shift[6:0], SLAVE_ADDR)) begin
                state_nxt = ST_ADDR_ACK;
                busy_set  = 1'b1;
              end else begin
                state_nxt = ST_WAIT_STOP;
                busy_clr  = 1'b1;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          // The R/W bit sits in shift[0] until the ACK clock completes.
          if (scl_fall) begin
            sda_set = 1'b1;
            sda_val = SDA_ACK;
          end else if (scl_rise) begin
            if (shift[0]) begin
              state_nxt = ST_RDATA;
              load_rd   = 1'b1;
            end else begin
              state_nxt = ST_PTR;
            end
          end
        end
        ST_PTR, ST_WDATA: begin
          // The first fall here closes the preceding ACK.
          if (scl_fall) begin
            sda_set = 1'b1;
          end else if (scl_rise) begin
            shift_in = 1'b1;
            cnt_inc  = 1'b1;
            if (last_bit) begin
              if (state == ST_PTR) begin
                ptr_set   = 1'b1;
                state_nxt = ST_PTR_ACK;
              end else begin
                wr_en     = 1'b1;
                ptr_inc   = 1'b1;
                state_nxt = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            sda_set = 1'b1;
            sda_val = SDA_ACK;
          end else if (scl_rise) begin
            state_nxt = ST_WDATA;
          end
        end
        ST_RDATA: begin
          // Each fall presents the next bit MSB first, starting with the fall
          // that closes the ACK which loaded the byte.
          if (scl_fall) begin
            shift_out = 1'b1;
            sda_set   = 1'b1;
            sda_val   = shift[7];
          end else if (scl_rise) begin
            cnt_inc = 1'b1;
            if (last_bit) begin
              ptr_inc   = 1'b1;
              state_nxt = ST_RDATA_ACK;
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_fall) begin
            sda_set = 1'b1;
          end else if (scl_rise) begin
            if (sda_s == SDA_NACK) begin
              state_nxt = ST_WAIT_STOP;
            end else begin
              load_rd   = 1'b1;
              state_nxt = ST_RDATA;
            end
          end
        end
        ST_WAIT_STOP: begin
          if (scl_fall) sda_set = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bit counter, shift register, pointer, SDA drive, busy flag and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      shift    <= '0;
      ptr      <= '0;
      SDA_O    <= SDA_RELEASE;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
      rd_pulse <= 1'b0;
    end else begin
      wr_pulse <= wr_en;
      rd_pulse <= load_rd;

      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 3'd1;

      if (shift_in)       shift <= rx_byte;
      else if (shift_out) shift <= {shift[6:0], 1'b0};
      else if (load_rd)   shift <= mem[ptr];

      if (ptr_set)      ptr <= rx_byte[PTR_W-1:0];
      else if (ptr_inc) ptr <= ptr + PTR_W'(1);

      if (sda_set) SDA_O <= sda_val;

      if (busy_set)      busy <= 1'b1;
      else if (busy_clr) busy <= 1'b0;
    end
  end

  // Byte store, written at the 8th rise of a data byte at the pre-increment pointer.
  // NOTE: the array is reset element by element because it must read back zero after reset; that keeps it in flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[ptr] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_i2c_mem_slave_burst.sv
// Bench for the burst I2C memory slave: bus-level master tasks, a byte model
// of the memory, and a queue of expected read bytes compared as they arrive.
module tb_i2c_mem_slave_burst;

  localparam logic [6:0] DEV = 7'h1F;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_m;
  logic       sda_line;
  logic       sda_o;
  logic       busy;
  logic       wr_pulse;
  logic       rd_pulse;
  logic [5:0] ptr;

  int chk_cnt = 0;
  int err_cnt = 0;

  int wr_cnt = 0;
  int rd_cnt = 0;
  int sda_low_cnt = 0;

  logic [7:0] model_mem [64];
  logic [5:0] model_ptr;
  logic [7:0] exp_q [$];
  logic [7:0] wbuf [4];

  assign sda_line = sda_m & sda_o;

  i2c_mem_slave_burst #(
    .SLAVE_ADDR  (DEV),
    .MEM_DEPTH   (64),
    .SYNC_STAGES (2)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .SCL_I    (scl),
    .SDA_I    (sda_line),
    .SDA_O    (sda_o),
    .busy     (busy),
    .wr_pulse (wr_pulse),
    .rd_pulse (rd_pulse),
    .ptr      (ptr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_pulse) wr_cnt <= wr_cnt + 1;
    if (rd_pulse) rd_cnt <= rd_cnt + 1;
    if (!sda_o)   sda_low_cnt <= sda_low_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(5);
    scl   = 1'b1; wait_clk(10);
    sda_m = 1'b0; wait_clk(10);
    scl   = 1'b0; wait_clk(5);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(5);
    scl   = 1'b1; wait_clk(10);
    sda_m = 1'b1; wait_clk(10);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clk(5);
    scl   = 1'b1; wait_clk(10);
    scl   = 1'b0; wait_clk(5);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_clk(5);
    scl   = 1'b1; wait_clk(5);
    b = sda_line; wait_clk(5);
    scl   = 1'b0; wait_clk(5);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(master_ack ? 1'b0 : 1'b1);
  endtask

  // Pointer byte then n data bytes from wbuf; model updated alongside.
  task automatic write_burst(input logic [7:0] p, input int n);
    logic ack;
    i2c_start();
    write_byte({DEV, 1'b0}, ack);
    check("wr_addr_ack", 32'(ack), 32'd0);
    write_byte(p, ack);
    check("wr_ptr_ack", 32'(ack), 32'd0);
    model_ptr = p[5:0];
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], ack);
      check("wr_data_ack", 32'(ack), 32'd0);
      model_mem[model_ptr] = wbuf[i];
      model_ptr++;
    end
    i2c_stop();
  endtask

  // Pointer write, repeated START, then n bytes read (ACK all but the last).
  task automatic read_bytes(input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] d;
    logic [7:0] e;
    i2c_start();
    write_byte({DEV, 1'b0}, ack);
    check("rd_addrw_ack", 32'(ack), 32'd0);
    write_byte(p, ack);
    check("rd_ptr_ack", 32'(ack), 32'd0);
    model_ptr = p[5:0];
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_mem[model_ptr]);
      model_ptr++;
    end
    i2c_start();
    write_byte({DEV, 1'b1}, ack);
    check("rd_addrr_ack", 32'(ack), 32'd0);
    check("rd_busy", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(d, i != n - 1);
      e = exp_q.pop_front();
      check("rd_data", 32'(d), 32'(e));
    end
    i2c_stop();
  endtask

  // Transfer to an address this slave must not claim.
  task automatic addr_nack(input logic [6:0] a, input int n);
    logic ack;
    i2c_start();
    write_byte({a, 1'b0}, ack);
    check("nack_addr", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      write_byte(8'h5A + 8'(i), ack);
      check("nack_data", 32'(ack), 32'd1);
    end
    i2c_stop();
  endtask

  initial begin
    int   base_wr;
    int   base_rd;
    int   base_low;
    logic [7:0] rd_addr;

    for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
    model_ptr = '0;
    rst   = 1'b1;
    scl   = 1'b1;
    sda_m = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);

    check("reset_sda",  32'(sda_o), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ptr",  32'(ptr), 32'd0);
    check("reset_wrp",  32'(wr_pulse), 32'd0);
    check("reset_rdp",  32'(rd_pulse), 32'd0);

    // Write burst at 0x05.
    base_wr = wr_cnt;
    wbuf[0] = 8'hA1; wbuf[1] = 8'hA2; wbuf[2] = 8'hA3;
    write_burst(8'h05, 3);
    check("burst_wr_pulses", 32'(wr_cnt - base_wr), 32'd3);
    check("burst_ptr", 32'(ptr), 32'd8);
    check("burst_busy", 32'(busy), 32'd0);

    // Random read back through repeated START.
    base_rd = rd_cnt;
    read_bytes(8'h05, 3);
    check("read_rd_pulses", 32'(rd_cnt - base_rd), 32'd3);
    check("read_ptr", 32'(ptr), 32'd8);
    check("read_busy", 32'(busy), 32'd0);

    // Pointer wrap on write and on read, and pointer byte modulo depth.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    write_burst(8'h3F, 2);
    check("wrap_wr_ptr", 32'(ptr), 32'd1);
    read_bytes(8'h3F, 2);
    check("wrap_rd_ptr", 32'(ptr), 32'd1);
    write_burst(8'h45, 0);
    check("ptr_modulo", 32'(ptr), 32'd5);

    // Foreign address and general call are ignored.
    base_wr  = wr_cnt;
    base_low = sda_low_cnt;
    addr_nack(7'h20, 3);
    addr_nack(7'h00, 1);
    check("mism_sda_low", 32'(sda_low_cnt - base_low), 32'd0);
    check("mism_wr_pulses", 32'(wr_cnt - base_wr), 32'd0);
    check("mism_busy", 32'(busy), 32'd0);
    check("mism_ptr", 32'(ptr), 32'd5);
    read_bytes(8'h05, 3);

    // STOP inside a data byte discards it.
    base_wr = wr_cnt;
    begin
      logic ack;
      i2c_start();
      write_byte({DEV, 1'b0}, ack);
      check("abort_addr_ack", 32'(ack), 32'd0);
      write_byte(8'h06, ack);
      check("abort_ptr_ack", 32'(ack), 32'd0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      i2c_stop();
    end
    check("abort_wr_pulses", 32'(wr_cnt - base_wr), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sda", 32'(sda_o), 32'd1);
    check("abort_ptr", 32'(ptr), 32'd6);
    read_bytes(8'h06, 2);

    // Reset while the slave is pulling SDA low for the address ACK of a read.
    write_burst(8'h05, 0);
    i2c_start();
    rd_addr = {DEV, 1'b1};
    for (int i = 7; i >= 0; i--) send_bit(rd_addr[i]);
    sda_m = 1'b1; wait_clk(5);
    scl   = 1'b1; wait_clk(5);
    check("rst_pre_sda", 32'(sda_o), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_sda", 32'(sda_o), 32'd1);
    check("rst_async_ptr", 32'(ptr), 32'd0);
    wait_clk(3);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) model_mem[i] = 8'h00;
    model_ptr = '0;
    wait_clk(5);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ptr", 32'(ptr), 32'd0);
    read_bytes(8'h05, 1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
